// File: rtl/elastic_reg_pkg.sv
// Shared constants and width helpers for the elastic register FIFO.
package elastic_reg_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 2;
  localparam int STALL_CNT_W   = 16;

  // Pointer width; a single-entry index still needs one bit.
  function automatic int ptr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/elastic_reg.sv
// Elastic register: circular-buffer FIFO with 1-cycle latency and registered in_ready.
// Optional stall statistics counter enabled by defining ELASTIC_REG_STATS_EN.
module elastic_reg
  import elastic_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [count_width(DEPTH)-1:0] count
`ifdef ELASTIC_REG_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0]        stall_cnt
`endif
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic             push, pop;

  // Handshake flags depend only on count_reg, so out_ready never reaches in_ready.
  assign in_ready  = (count_reg != CW'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign out_data  = mem_reg[rd_ptr_reg];
  assign count     = count_reg;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) begin
      wr_ptr_next = (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
    end
    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // One register per entry, written only when the write pointer selects it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        mem_reg[gi] <= '0;
      end else if (push && (wr_ptr_reg == PW'(gi))) begin
        mem_reg[gi] <= in_data;
      end
    end
  end

`ifdef ELASTIC_REG_STATS_EN
  logic [STALL_CNT_W-1:0] stall_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if (in_valid && !in_ready && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_elastic_reg.sv
// Self-checking bench: DEPTH=2 and DEPTH=3 instances share stimulus, checked against queue models.
module tb_elastic_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset     = 1'b0;
  logic [7:0] in_data   = 8'h00;
  logic       in_valid  = 1'b0;
  logic       out_ready = 1'b0;

  logic [1:0]       ir;
  logic [1:0]       ov;
  logic [1:0][7:0]  od;
  logic [1:0][1:0]  cnt;
`ifdef ELASTIC_REG_STATS_EN
  logic [1:0][15:0] stall;
  int               stall_m [2];
`endif

  int  tests = 0;
  int  fails = 0;
  bit  armed = 1'b0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  elastic_reg #(.WIDTH(8), .DEPTH(2)) u_dut2 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir[0]), .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .count(cnt[0])
`ifdef ELASTIC_REG_STATS_EN
    , .stall_cnt(stall[0])
`endif
  );

  elastic_reg #(.WIDTH(8), .DEPTH(3)) u_dut3 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir[1]), .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .count(cnt[1])
`ifdef ELASTIC_REG_STATS_EN
    , .stall_cnt(stall[1])
`endif
  );

  task automatic check(input string name, input int k, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s dut%0d at %0t: got %0h expected %0h", name, k, $time, act, exp);
    end
  endtask

  // Reference model: FIFO queue bounded by DEPTH; full blocks push even when popping.
  initial begin
    bit acc0, acc1;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        q0.delete();
        q1.delete();
`ifdef ELASTIC_REG_STATS_EN
        stall_m[0] = 0;
        stall_m[1] = 0;
`endif
      end else begin
        acc0 = in_valid && (q0.size() < 2);
        acc1 = in_valid && (q1.size() < 3);
`ifdef ELASTIC_REG_STATS_EN
        if (in_valid && !acc0 && stall_m[0] < 65535) stall_m[0]++;
        if (in_valid && !acc1 && stall_m[1] < 65535) stall_m[1]++;
`endif
        if (q0.size() != 0 && out_ready) void'(q0.pop_front());
        if (q1.size() != 0 && out_ready) void'(q1.pop_front());
        if (acc0) q0.push_back(in_data);
        if (acc1) q1.push_back(in_data);
      end
    end
  end

  // Compare on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        for (int k = 0; k < 2; k++) begin
          int s;
          int d;
          logic [7:0] front;
          s = (k == 0) ? q0.size() : q1.size();
          d = k + 2;
          front = 8'h00;
          if (s != 0) front = (k == 0) ? q0[0] : q1[0];
          check("in_ready", k, ir[k], (s < d) ? 1 : 0);
          check("out_valid", k, ov[k], (s != 0) ? 1 : 0);
          check("count", k, cnt[k], s);
          if (s != 0) check("out_data", k, od[k], front);
`ifdef ELASTIC_REG_STATS_EN
          check("stall_cnt", k, stall[k], stall_m[k]);
`endif
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lit_state(input string tag, input int k, input int e_ir, input int e_ov,
                           input int e_cnt, input int e_od);
    check({tag, "_ir"}, k, ir[k], e_ir);
    check({tag, "_ov"}, k, ov[k], e_ov);
    check({tag, "_cnt"}, k, cnt[k], e_cnt);
    if (e_od >= 0) check({tag, "_od"}, k, od[k], e_od);
  endtask

  initial begin
    #1;
    reset = 1'b1;
    armed = 1'b1;
    cyc();
    cyc();
    lit_state("rst", 0, 1, 0, 0, 0);
    lit_state("rst", 1, 1, 0, 0, 0);
    reset = 1'b0;

    // First push after reset, 1-cycle latency.
    in_valid = 1'b1; in_data = 8'h44; out_ready = 1'b0;
    cyc();
    lit_state("first", 0, 1, 1, 1, 8'h44);
    check("model_first", 0, q0.size(), 1);

    // Fill DEPTH=2, third word refused.
    in_data = 8'h54; cyc();
    lit_state("fill2", 0, 0, 1, 2, 8'h44);
    in_data = 8'h66; cyc();
    lit_state("full2", 0, 0, 1, 2, 8'h44);
    lit_state("full3", 1, 0, 1, 3, 8'h44);

    // Full with push and pop together: pop only.
    out_ready = 1'b1; cyc();
    lit_state("fullpop", 0, 1, 1, 1, 8'h54);
    lit_state("fullpop", 1, 1, 1, 2, 8'h54);
    cyc();
    lit_state("late66", 0, 1, 1, 1, 8'h66);
    in_valid = 1'b0; cyc(); cyc();
    lit_state("drain", 0, 1, 0, 0, -1);
    lit_state("drain", 1, 1, 0, 0, -1);

    // Streaming 1..10 back-to-back.
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      cyc();
      lit_state("stream", 1, 1, 1, 1, i);
    end
    in_valid = 1'b0; cyc();
    lit_state("stream_end", 1, 1, 0, 0, -1);

    // Data wiggling while stalled must not disturb stored entries.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h11; cyc();
    in_data = 8'h22; cyc();
    in_data = 8'h33; cyc();
    in_data = 8'h99; cyc();
    in_data = 8'hAA; cyc();
    in_valid = 1'b0; out_ready = 1'b1; cyc();
    lit_state("stall_order", 0, 1, 1, 1, 8'h22);
    lit_state("stall_order", 1, 1, 1, 2, 8'h22);
    cyc(); cyc(); cyc();

    // Asynchronous reset in mid-cycle with two entries held.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h77; cyc();
    in_data = 8'h88; cyc();
    in_valid = 1'b0;
    lit_state("pre_rst", 1, 1, 1, 2, 8'h77);
    #2 reset = 1'b1;
    #1;
    lit_state("async_rst", 0, 1, 0, 0, 0);
    lit_state("async_rst", 1, 1, 0, 0, 0);
    cyc();
    lit_state("hold_rst", 1, 1, 0, 0, 0);
    #2 reset = 1'b0;
    in_valid = 1'b1; in_data = 8'hA5; cyc();
    in_valid = 1'b0;
    lit_state("post_rst", 0, 1, 1, 1, 8'hA5);
    lit_state("post_rst", 1, 1, 1, 1, 8'hA5);
    out_ready = 1'b1; cyc();
    lit_state("post_rst_pop", 1, 1, 0, 0, -1);

`ifdef ELASTIC_REG_STATS_EN
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h01; cyc();
    in_data = 8'h02; cyc();
    for (int i = 0; i < 5; i++) cyc();
    check("stall_lit", 0, stall[0], 5);
    check("stall_lit", 1, stall[1], 4);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("stall_rst", 0, stall[0], 0);
    cyc();
    #2 reset = 1'b0;
    cyc();
`endif

    cyc(); cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/elastic_reg.md
ELASTIC_REG -- requirements
Module: elastic_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning payload width in bits (legal: >=1).
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning number of storage entries (legal: >=2; non-power-of-two allowed).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-005 The block SHALL have port in_data, input, WIDTH, meaning upstream payload.
REQ-006 The block SHALL have port in_valid, input, 1, meaning upstream offers in_data.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the block can accept an entry this cycle.
REQ-008 The block SHALL have port out_data, output, WIDTH, meaning payload of the oldest stored entry.
REQ-009 The block SHALL have port out_valid, output, 1, meaning out_data holds a valid entry.
REQ-010 The block SHALL have port out_ready, input, 1, meaning downstream accepts out_data.
REQ-011 The block SHALL have port count, output, $clog2(DEPTH+1), meaning current number of stored entries.

Function
REQ-012 Push SHALL occur on a clock edge where in_valid && in_ready; pop SHALL occur where out_valid && out_ready.
REQ-013 Storage SHALL be a circular buffer with write pointer and read pointer, each wrapping from DEPTH-1 to 0.
REQ-014 in_ready SHALL equal (count < DEPTH), decoded from registered state only, with no combinational path from out_ready.
REQ-015 out_valid SHALL equal (count != 0); out_data SHALL equal the entry at the read pointer.
REQ-016 Latency SHALL be exactly 1 cycle: data pushed at edge N is visible on out_data with out_valid=1 after edge N.
REQ-017 Push and pop in the same cycle SHALL leave count unchanged and advance both pointers.
REQ-018 When full, a push SHALL NOT occur even if a pop occurs in the same cycle; in_ready rises on the cycle after the pop.
REQ-019 When empty, pop SHALL NOT occur (out_valid=0); push alone increments count.
REQ-020 Order SHALL be strict FIFO; no entry SHALL be lost, duplicated or reordered.
REQ-021 Sustained throughput SHALL be one entry per cycle while 0 < count < DEPTH and both sides are ready.
REQ-022 in_data changes while in_valid && !in_ready SHALL have no effect on stored state.

Reset
REQ-023 Assertion of reset SHALL immediately clear count, both pointers and all storage entries to 0, independent of clk.
REQ-024 During and after reset: in_ready=1, out_valid=0, out_data=0, count=0; entries held at reset time are discarded.
REQ-025 The first push SHALL be accepted on the first rising clk edge after reset deasserts.

Configuration
REQ-026 With macro ELASTIC_REG_STATS_EN defined, the block SHALL add output stall_cnt (16 bits) counting cycles with in_valid && !in_ready, saturating at 16'hFFFF, cleared by reset.
REQ-027 Without ELASTIC_REG_STATS_EN, stall_cnt and its counter SHALL NOT exist; all other behaviour SHALL be identical.

Structure
REQ-028 Package elastic_reg_pkg SHALL hold the default WIDTH/DEPTH constants, the stall counter width constant (16) and a pointer/count width helper function.
REQ-029 No sub-module SHALL be instantiated; storage is a flat register array inside elastic_reg.

Verification
REQ-030 Reset then push 8'h44 at edge 1 -> out_valid=1, out_data=8'h44, count=1 after edge 1; in_ready stays 1.
REQ-031 DEPTH=2, out_ready=0, push 8'h44, 8'h54, 8'h66 on consecutive cycles -> 8'h66 not accepted, in_ready=0, count=2; then out_ready=1 -> 8'h44, 8'h54, 8'h66 delivered in order.
REQ-032 DEPTH=3, out_ready=1, in_valid=1 with data 1..10 back-to-back -> outputs 1..10 one per cycle, count stays 1, pointers wrap cleanly.
REQ-033 Full (count=DEPTH), assert out_ready and in_valid in the same cycle -> pop only, count=DEPTH-1, in_ready=1 next cycle.
REQ-034 count=2, assert reset mid-cycle -> out_valid=0, count=0, out_data=0 immediately; post-reset push of 8'hA5 emerges alone.
REQ-035 With ELASTIC_REG_STATS_EN, hold full with in_valid=1 for 5 cycles -> stall_cnt=5; reset -> stall_cnt=0.
